// File: rtl/dmux_stream_router.sv
// dmux_stream_router: valid/ready demux into NCH registered one-entry channel slots,
// with all-or-nothing broadcast and a saturating count of discarded out-of-range words.
module dmux_stream_router #(
    parameter int WIDTH = 16,
    parameter int NCH = 8,
    parameter int SELW = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_bcast,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [7:0]           drop_count
);
    logic [NCH-1:0] can_take, hit, load;
    logic in_range, uni_ready, xfer, drop;
    assign can_take = ~out_valid | out_ready;
    always_comb begin
        hit = '0;
        for (int k = 0; k < NCH; k++) hit[k] = int'(in_sel) == k;
    end
    assign in_range = |hit;
    // Out-of-range selections are always accepted so the producer never stalls on them.
    assign uni_ready = in_range ? |(hit & can_take) : 1'b1;
    assign in_ready = in_bcast ? &can_take : uni_ready;
    assign xfer = in_valid & in_ready;
    assign load = {NCH{xfer}} & (in_bcast ? {NCH{1'b1}} : hit);
    assign drop = xfer & ~in_bcast & ~in_range;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= '0;
            out_data <= '0;
            drop_count <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (load[k]) begin
                    out_valid[k] <= 1'b1;
                    out_data[k*WIDTH +: WIDTH] <= in_data;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_dmux_stream_router.sv
// tb_dmux_stream_router: directed stimulus with per-channel expected-word queues drained by a monitor;
// a second NCH=6 instance covers out-of-range drops and counter saturation.
module tb_dmux_stream_router;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] in_data = '0;
    logic [2:0] in_sel = '0;
    logic in_bcast = 1'b0, in_valid = 1'b0, in_ready;
    logic [127:0] out_data;
    logic [7:0] out_valid, out_ready = '0, drop_count;
    logic [15:0] s_data = '0;
    logic [2:0] s_sel = '0;
    logic s_bcast = 1'b0, s_valid = 1'b0, s_ready;
    logic [95:0] s_odata;
    logic [5:0] s_ovalid, s_oready = '0;
    logic [7:0] s_drop;
    int errors = 0, checks = 0;
    logic [15:0] q [8][$];

    always #5 clk = ~clk;

    dmux_stream_router dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .drop_count(drop_count)
    );

    dmux_stream_router #(.WIDTH(16), .NCH(6), .SELW(3)) dut6 (
        .clk(clk), .reset(reset), .in_data(s_data), .in_sel(s_sel), .in_bcast(s_bcast),
        .in_valid(s_valid), .in_ready(s_ready), .out_data(s_odata), .out_valid(s_ovalid),
        .out_ready(s_oready), .drop_count(s_drop)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word for one cycle; the word is queued as expected output only if it should be accepted.
    task automatic offer(input logic [15:0] d, input logic [2:0] sel, input logic bc, input logic exp_rdy);
        in_data = d;
        in_sel = sel;
        in_bcast = bc;
        in_valid = 1'b1;
        #1;
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        if (exp_rdy) begin
            if (bc) for (int k = 0; k < 8; k++) q[k].push_back(d);
            else q[sel].push_back(d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bcast = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 8; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word ch%0d: got %h expected none", k, out_data[k*16 +: 16]);
                    end else begin
                        chk($sformatf("sb_ch%0d", k), {16'b0, out_data[k*16 +: 16]}, {16'b0, q[k].pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        step();
        step();
        chk("rst_out_valid", {24'b0, out_valid}, 32'h0);
        chk("rst_drop", {24'b0, drop_count}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        reset = 1'b0;
        step();

        // Single word held without backpressure relief, then released.
        offer(16'hA5A5, 3'd5, 1'b0, 1'b1);
        chk("t1_valid", {24'b0, out_valid}, 32'h20);
        chk("t1_slice5", {16'b0, out_data[5*16 +: 16]}, 32'hA5A5);
        for (int i = 0; i < 3; i++) offer(16'h5555, 3'd5, 1'b0, 1'b0);
        chk("t1_stable", {16'b0, out_data[5*16 +: 16]}, 32'hA5A5);
        out_ready = 8'h20;
        offer(16'h5555, 3'd5, 1'b0, 1'b1);
        chk("t1_slice5_new", {16'b0, out_data[5*16 +: 16]}, 32'h5555);
        step();
        out_ready = 8'h00;
        chk("t1_drained", {24'b0, out_valid}, 32'h0);

        // Back-to-back stream with the consumer always ready: no bubbles.
        out_ready = 8'h04;
        for (int i = 1; i <= 8; i++) begin
            offer(16'(i), 3'd2, 1'b0, 1'b1);
            chk("t2_valid", {31'b0, out_valid[2]}, 32'h1);
            chk("t2_slice2", {16'b0, out_data[2*16 +: 16]}, i);
        end
        step();
        out_ready = 8'h00;
        chk("t2_drained", {24'b0, out_valid}, 32'h0);

        // Broadcast blocked by one full channel, then released.
        offer(16'h0333, 3'd3, 1'b0, 1'b1);
        offer(16'h1234, 3'd0, 1'b1, 1'b0);
        offer(16'h1234, 3'd6, 1'b1, 1'b0);
        chk("t3_no_load", {24'b0, out_valid}, 32'h08);
        out_ready = 8'h08;
        offer(16'h1234, 3'd0, 1'b1, 1'b1);
        out_ready = 8'h00;
        chk("t3_all_valid", {24'b0, out_valid}, 32'hFF);
        for (int k = 0; k < 8; k++) chk("t3_slice", {16'b0, out_data[k*16 +: 16]}, 32'h1234);
        out_ready = 8'hFF;
        step();
        out_ready = 8'h00;
        chk("t3_drained", {24'b0, out_valid}, 32'h0);

        // Simultaneous drain and load keeps the slot valid with the new word.
        offer(16'hBEEF, 3'd4, 1'b0, 1'b1);
        out_ready = 8'h10;
        offer(16'hCAFE, 3'd4, 1'b0, 1'b1);
        chk("t4_valid", {31'b0, out_valid[4]}, 32'h1);
        chk("t4_slice4", {16'b0, out_data[4*16 +: 16]}, 32'hCAFE);
        step();
        out_ready = 8'h00;

        // Out-of-range selections on the six-channel instance.
        s_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            s_sel = 3'(6 + (i % 2));
            #1;
            if (!s_ready) chk("t5_ready", {31'b0, s_ready}, 32'h1);
            step();
            if (s_ovalid != 6'b0) chk("t5_ovalid", {26'b0, s_ovalid}, 32'h0);
            if (i == 99) chk("t5_drop100", {24'b0, s_drop}, 32'd100);
        end
        s_valid = 1'b0;
        chk("t5_ready_end", {31'b0, s_ready}, 32'h1);
        chk("t5_drop_sat", {24'b0, s_drop}, 32'd255);
        chk("t5_ovalid_end", {26'b0, s_ovalid}, 32'h0);

        // Asynchronous reset mid-cycle with buffered words.
        offer(16'h0F00, 3'd0, 1'b0, 1'b1);
        offer(16'h0F07, 3'd7, 1'b0, 1'b1);
        chk("t6_filled", {24'b0, out_valid}, 32'h81);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_valid_async", {24'b0, out_valid}, 32'h0);
        chk("t6_data_async", {31'b0, |out_data}, 32'h0);
        chk("t6_drop_async", {24'b0, s_drop}, 32'h0);
        for (int k = 0; k < 8; k++) q[k].delete();
        step();
        reset = 1'b0;
        in_sel = 3'd7;
        in_bcast = 1'b0;
        #1;
        chk("t6_ready_uni", {31'b0, in_ready}, 32'h1);
        in_bcast = 1'b1;
        #1;
        chk("t6_ready_bc", {31'b0, in_ready}, 32'h1);
        in_bcast = 1'b0;
        s_sel = 3'd7;
        #1;
        chk("t6_ready_oor", {31'b0, s_ready}, 32'h1);
        step();

        for (int k = 0; k < 8; k++) chk($sformatf("left_ch%0d", k), q[k].size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmux_stream_router.md
Name: dmux_stream_router

Overview:
- Parametrised, registered successor to the combinational DMux8Way16 family.
- Routes a valid/ready input stream of WIDTH-bit words to one of NCH output channels selected by in_sel, or to all channels in broadcast mode.
- Each channel holds a one-entry output register with its own valid/ready handshake, giving backpressure per channel.
- Sits between a single producer and multiple independent consumers in the datapath.

Parameters:
- WIDTH, 16, data word width in bits.
- NCH, 8, number of output channels; must satisfy 1 <= NCH <= 2**SELW.
- SELW, 3, width of in_sel.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_sel  input  SELW  destination channel index; ignored when in_bcast=1.
- in_bcast  input  1  1 = deliver the word to every channel.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  block can accept this cycle.
- out_data  output  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  NCH  bit k = channel k holds a word.
- out_ready  input  NCH  bit k = consumer k takes the word this cycle.
- drop_count  output  8  saturating count of discarded out-of-range transfers.

Behaviour:
- Per channel k, state is slot_valid[k] and slot_data[k]; these drive out_valid[k] and out_data slice k directly (registered outputs).
- can_take[k] = ~slot_valid[k] | out_ready[k]. A word consumed this cycle frees the slot in the same cycle.
- in_ready is combinational and does not depend on in_valid:
  - Unicast (in_bcast=0) with in_sel < NCH: in_ready = can_take[in_sel].
  - Broadcast (in_bcast=1): in_ready = AND of can_take over all NCH channels. All-or-nothing; no partial delivery.
  - Unicast with in_sel >= NCH: in_ready = 1.
- A transfer occurs when in_valid & in_ready.
- load[k] is set on a unicast transfer with in_sel==k, or on a broadcast transfer for every k.
- Channel update at the rising edge, in priority order:
  - If load[k]: slot_valid[k] <= 1 and slot_data[k] <= in_data. This covers a simultaneous drain and load, where the slot stays valid with the new word.
  - Else if out_ready[k]: slot_valid[k] <= 0, and slot_data[k] holds its value.
  - Else: no change.
- Out-of-range unicast transfer (in_sel >= NCH):
  - The word is accepted and discarded; no channel is loaded.
  - drop_count increments by 1, saturating at 255 (stays at 255).
- Latency: one cycle from transfer to out_valid. Sustained throughput is one word per cycle per channel while out_ready[k] is held high.
- Stability: while out_valid[k] & ~out_ready[k], out_data slice k and out_valid[k] must not change.
- out_ready[k] asserted while out_valid[k]=0 has no effect.
- Reset (asynchronous, any time including mid-transfer):
  - All slot_valid <= 0, all slot_data <= 0, drop_count <= 0.
  - Buffered words are lost.
  - After reset, in_ready = 1 for any in-range or out-of-range selection and for broadcast.
- The combinational path out_ready -> in_ready is intentional; integrators must not close it back through the producer combinationally.

Test Plan:
- Reset, then send 16'hA5A5 with sel=5 while all out_ready=0 -> next cycle out_valid=8'b0010_0000 and slice 5 = A5A5; later sel=5 offers see in_ready=0 until out_ready[5]=1.
- Drive out_ready[2]=1 continuously and stream 16'h0001..16'h0008 to sel=2 back-to-back -> in_ready stays 1; channel 2 emits 1..8 on consecutive cycles with no bubbles.
- Broadcast 16'h1234 with channel 3 full and out_ready[3]=0 -> in_ready=0 and no channel loads; raise out_ready[3] -> transfer occurs and all 8 out_valid bits are 1 with data 1234 next cycle.
- Build with NCH=6, send sel=6 and sel=7 repeatedly 300 times -> in_ready=1 throughout, no out_valid change, drop_count reaches 255 and holds.
- Fill channels 0 and 7, assert reset asynchronously mid-cycle -> out_valid=0, out_data=0 and drop_count=0 immediately, without waiting for a clock edge; in_ready=1 after reset release.
- Simultaneous drain and load on channel 4 (slot valid with 16'hBEEF, out_ready[4]=1, new word 16'hCAFE to sel=4) -> next cycle out_valid[4]=1 and slice 4 = CAFE.
